// File: rtl/max7219_pkg.sv
// Shared constants, state encoding and frame layout
// for the MAX7219 serial transmit slice.
package max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam int unsigned INIT_FRAMES = 5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_LATCH
  } state_e;

  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  function automatic frame_t mk_frame(
    input logic [3:0] a,
    input logic [7:0] d
  );
    frame_t f;
    f.pad  = 4'h0;
    f.addr = a;
    f.data = d;
    return f;
  endfunction

endpackage

// File: rtl/max7219_shifter.sv
// LOW/HIGH/TAIL/LATCH serializer: shifts one 16-bit
// word out MSB first, LOAD low for the whole frame.
module max7219_shifter
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [15:0] word_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sck_o,
  output logic        din_o,
  output logic        load_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    word_q, word_d;
  logic           tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    tick    = (cnt_q == CMAX);
    if (state_q != ST_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      ST_LOW: begin
        if (tick) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) begin
          if (bit_q == 4'd0) begin
            state_d = ST_TAIL;
          end else begin
            bit_d   = bit_q - 4'd1;
            state_d = ST_LOW;
          end
        end
      end
      ST_TAIL: begin
        if (tick) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (tick) state_d = ST_IDLE;
      end
      default: ;
    endcase
    done_o = (state_q == ST_LATCH) && tick;
    // a start in the final LATCH cycle chains frames with no gap
    if (start_i && (state_q == ST_IDLE || done_o)) begin
      state_d = ST_LOW;
      word_d  = word_i;
      bit_d   = 4'd15;
      cnt_d   = '0;
    end
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    sck_o  = (state_q == ST_HIGH);
    load_o = !(state_q == ST_LOW ||
               state_q == ST_HIGH ||
               state_q == ST_TAIL);
    din_o  = (state_q == ST_LOW ||
              state_q == ST_HIGH) && word_q[bit_q];
  end

endmodule

// File: rtl/max7219_spi_tx.sv
// MAX7219 transmit stage: init ROM playback after
// reset, then valid/ready user register writes.
module max7219_spi_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 5,
  parameter logic [3:0]  INTENSITY  = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       max_din,
  output logic       max_clk,
  output logic       max_load
);

  state_e     seq_q, seq_d;
  logic [2:0] idx_q, idx_d;
  frame_t     rom_w, word;
  logic       start, sh_busy, sh_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq_q <= ST_INIT;
      idx_q <= '0;
    end else begin
      seq_q <= seq_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    unique case (idx_q)
      3'd0:    rom_w = mk_frame(REG_SHUTDOWN, 8'h01);
      3'd1:    rom_w = mk_frame(REG_SCANLIMIT,
                                {5'b0, SCAN_LIMIT});
      3'd2:    rom_w = mk_frame(REG_DECODE, 8'hFF);
      3'd3:    rom_w = mk_frame(REG_INTENSITY,
                                {4'b0, INTENSITY});
      default: rom_w = mk_frame(REG_TEST, 8'h00);
    endcase
  end

  always_comb begin
    seq_d     = seq_q;
    idx_d     = idx_q;
    start     = 1'b0;
    word      = mk_frame(wr_addr, wr_data);
    init_done = (seq_q == ST_IDLE);
    wr_ready  = init_done && !sh_busy;
    unique case (seq_q)
      ST_INIT: begin
        if (!sh_busy || sh_done) begin
          if (idx_q < 3'(INIT_FRAMES)) begin
            start = 1'b1;
            word  = rom_w;
            idx_d = idx_q + 3'd1;
          end else begin
            seq_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: start = wr_valid && wr_ready;
      default: ;
    endcase
  end

  max7219_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .start_i (start),
    .word_i  (word),
    .busy_o  (sh_busy),
    .done_o  (sh_done),
    .sck_o   (max_clk),
    .din_o   (max_din),
    .load_o  (max_load)
  );

endmodule

// File: tb/tb_max7219_spi_tx.sv
// Directed bench for max7219_spi_tx at CLK_DIV=5
// and CLK_DIV=1.
module tb_max7219_spi_tx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       v5 = 1'b0, v1 = 1'b0;
  logic [3:0] a5 = '0, a1 = '0;
  logic [7:0] d5 = '0, d1 = '0;
  logic       rdy5, rdy1, done5, done1;
  logic       din5, din1, sck5, sck1, ld5, ld1;
  logic       sel = 1'b0;
  logic       m_load, m_clk, m_din;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  int         rel = 0;

  assign m_load = sel ? ld1  : ld5;
  assign m_clk  = sel ? sck1 : sck5;
  assign m_din  = sel ? din1 : din5;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  max7219_spi_tx #(.CLK_DIV(5)) dut5 (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_valid  (v5),
    .wr_addr   (a5),
    .wr_data   (d5),
    .wr_ready  (rdy5),
    .init_done (done5),
    .max_din   (din5),
    .max_clk   (sck5),
    .max_load  (ld5)
  );

  max7219_spi_tx #(.CLK_DIV(1)) dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_valid  (v1),
    .wr_addr   (a1),
    .wr_data   (d1),
    .wr_ready  (rdy1),
    .init_done (done1),
    .max_din   (din1),
    .max_clk   (sck1),
    .max_load  (ld1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic cap(input int d,
                     output logic [15:0] w,
                     output int lowlen,
                     output int tfall);
    int g, edges, hi, unstable;
    logic pc, pd;
    g = 0; edges = 0; hi = 0; unstable = 0;
    pc = 1'b0; pd = 1'b0;
    w = '0; lowlen = 0; tfall = 0;
    while (m_load !== 1'b0 && g < 400) begin
      @(negedge clock);
      g++;
    end
    chk("load_fall_seen", 32'(m_load), 0);
    tfall = cyc;
    while (m_load === 1'b0 && lowlen < 400) begin
      lowlen++;
      if (m_clk === 1'b1) hi++;
      if (m_clk === 1'b1 && pc === 1'b0) begin
        edges++;
        w = {w[14:0], m_din};
        if (m_din !== pd) unstable++;
      end
      pc = m_clk;
      pd = m_din;
      @(negedge clock);
    end
    chk("sck_rise_count", edges, 16);
    chk("sck_high_cycles", hi, 16 * d);
    chk("din_stable_at_rise", unstable, 0);
    chk("din_zero_at_latch", 32'(m_din), 0);
    chk("sck_low_at_latch", 32'(m_clk), 0);
  endtask

  task automatic run_init(input bit poke);
    logic [15:0] rom [5];
    logic [15:0] w;
    int ll, tf;
    rom = '{16'h0C01, 16'h0B07, 16'h09FF,
            16'h0A08, 16'h0F00};
    for (int i = 0; i < 5; i++) begin
      cap(5, w, ll, tf);
      chk($sformatf("init_word%0d", i), 32'(w),
          32'(rom[i]));
      chk($sformatf("init_fall%0d", i), tf - rel,
          1 + 170 * i);
      chk($sformatf("init_low%0d", i), ll, 165);
      chk($sformatf("init_done_low%0d", i),
          32'(done5), 0);
      if (poke && i == 0) begin
        v5 = 1'b1; a5 = 4'h3; d5 = 8'h77;
      end
    end
    wait_cyc(rel + 850);
    chk("init_done_850", 32'(done5), 0);
    chk("ready_850", 32'(rdy5), 0);
    @(negedge clock);
    chk("init_cycle", cyc - rel, 851);
    chk("init_done_851", 32'(done5), 1);
    chk("ready_851", 32'(rdy5), 1);
  endtask

  initial begin
    logic [15:0] w;
    int ll, tf, tf1, t0, g, lows;

    repeat (3) @(negedge clock);
    chk("rst_load", 32'(ld5), 1);
    chk("rst_sck", 32'(sck5), 0);
    chk("rst_din", 32'(din5), 0);
    chk("rst_ready", 32'(rdy5), 0);
    chk("rst_done", 32'(done5), 0);
    chk("rst_load1", 32'(ld1), 1);
    reset_n = 1'b1;
    rel = cyc;

    // write requested during init, taken at 851
    run_init(1'b1);
    t0 = cyc;
    @(negedge clock);
    chk("early_req_taken", 32'(rdy5), 0);
    v5 = 1'b0; a5 = '0; d5 = '0;
    cap(5, w, ll, tf);
    chk("early_req_word", 32'(w), 32'h0377);
    chk("early_req_fall", tf - t0, 1);
    lows = 0;
    repeat (200) begin
      @(negedge clock);
      if (ld5 === 1'b0) lows++;
    end
    chk("no_extra_frame", lows, 0);

    chk("idle_ready", 32'(rdy5), 1);
    v5 = 1'b1; a5 = 4'h1; d5 = 8'h5A;
    t0 = cyc;
    @(negedge clock);
    v5 = 1'b0; a5 = 4'hF; d5 = 8'h00;
    cap(5, w, ll, tf);
    chk("w015A_word", 32'(w), 32'h015A);
    chk("w015A_low", ll, 165);
    chk("w015A_fall", tf - t0, 1);
    g = 0;
    while (rdy5 !== 1'b1 && g < 400) begin
      @(negedge clock);
      g++;
    end
    chk("w015A_busy", cyc - t0 - 1, 170);

    v5 = 1'b1; a5 = 4'h2; d5 = 8'h33;
    cap(5, w, ll, tf1);
    chk("b2b_word0", 32'(w), 32'h0233);
    a5 = 4'h4; d5 = 8'hC3;
    cap(5, w, ll, tf);
    v5 = 1'b0;
    chk("b2b_word1", 32'(w), 32'h04C3);
    chk("b2b_period", tf - tf1, 171);
    g = 0;
    while (rdy5 !== 1'b1 && g < 400) begin
      @(negedge clock);
      g++;
    end
    chk("b2b_ready_back", 32'(rdy5), 1);

    v5 = 1'b1; a5 = 4'h1; d5 = 8'hFF;
    t0 = cyc;
    @(negedge clock);
    v5 = 1'b0;
    wait_cyc(t0 + 83);
    chk("mid_load", 32'(ld5), 0);
    chk("mid_din_bit7", 32'(din5), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_load", 32'(ld5), 1);
    chk("arst_sck", 32'(sck5), 0);
    chk("arst_din", 32'(din5), 0);
    chk("arst_done", 32'(done5), 0);
    chk("arst_ready", 32'(rdy5), 0);
    @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    run_init(1'b0);

    sel = 1'b1;
    chk("d1_done", 32'(done1), 1);
    chk("d1_ready", 32'(rdy1), 1);
    v1 = 1'b1; a1 = 4'h8; d1 = 8'hA5;
    t0 = cyc;
    @(negedge clock);
    v1 = 1'b0;
    cap(1, w, ll, tf);
    chk("d1_word", 32'(w), 32'h08A5);
    chk("d1_low", ll, 33);
    chk("d1_fall", tf - t0, 1);
    g = 0;
    while (rdy1 !== 1'b1 && g < 100) begin
      @(negedge clock);
      g++;
    end
    chk("d1_busy", cyc - t0 - 1, 34);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
